// File: rtl/reorder_buffer_pkg.sv
// Shared definitions for the reorder buffer: sizes, opcode encoding,
// entry kinds and control-state encodings.
package reorder_buffer_pkg;

  localparam int ROB_SIZE_WIDTH   = 3;
  localparam int ROB_ENTRIES      = 1 << ROB_SIZE_WIDTH;
  localparam int DEPENDENCY_WIDTH = ROB_SIZE_WIDTH + 1;  // MSB=1 means "no dependency"
  localparam int XLEN             = 32;
  localparam int REG_CNT_WIDTH    = 5;
  localparam int INST_OP_WIDTH    = 6;

  // Opcode encoding shared with the decoder. Branches and stores are kept
  // contiguous so that kind classification is a simple range check.
  localparam logic [INST_OP_WIDTH-1:0] OP_NOP   = 6'd0;
  localparam logic [INST_OP_WIDTH-1:0] OP_LUI   = 6'd1;
  localparam logic [INST_OP_WIDTH-1:0] OP_AUIPC = 6'd2;
  localparam logic [INST_OP_WIDTH-1:0] OP_JAL   = 6'd3;
  localparam logic [INST_OP_WIDTH-1:0] OP_JALR  = 6'd4;
  localparam logic [INST_OP_WIDTH-1:0] OP_BEQ   = 6'd5;
  localparam logic [INST_OP_WIDTH-1:0] OP_BNE   = 6'd6;
  localparam logic [INST_OP_WIDTH-1:0] OP_BLT   = 6'd7;
  localparam logic [INST_OP_WIDTH-1:0] OP_BGE   = 6'd8;
  localparam logic [INST_OP_WIDTH-1:0] OP_BLTU  = 6'd9;
  localparam logic [INST_OP_WIDTH-1:0] OP_BGEU  = 6'd10;
  localparam logic [INST_OP_WIDTH-1:0] OP_LB    = 6'd11;
  localparam logic [INST_OP_WIDTH-1:0] OP_LH    = 6'd12;
  localparam logic [INST_OP_WIDTH-1:0] OP_LW    = 6'd13;
  localparam logic [INST_OP_WIDTH-1:0] OP_LBU   = 6'd14;
  localparam logic [INST_OP_WIDTH-1:0] OP_LHU   = 6'd15;
  localparam logic [INST_OP_WIDTH-1:0] OP_SB    = 6'd16;
  localparam logic [INST_OP_WIDTH-1:0] OP_SH    = 6'd17;
  localparam logic [INST_OP_WIDTH-1:0] OP_SW    = 6'd18;
  localparam logic [INST_OP_WIDTH-1:0] OP_ADDI  = 6'd19;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLTI  = 6'd20;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLTIU = 6'd21;
  localparam logic [INST_OP_WIDTH-1:0] OP_XORI  = 6'd22;
  localparam logic [INST_OP_WIDTH-1:0] OP_ORI   = 6'd23;
  localparam logic [INST_OP_WIDTH-1:0] OP_ANDI  = 6'd24;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLLI  = 6'd25;
  localparam logic [INST_OP_WIDTH-1:0] OP_SRLI  = 6'd26;
  localparam logic [INST_OP_WIDTH-1:0] OP_SRAI  = 6'd27;
  localparam logic [INST_OP_WIDTH-1:0] OP_ADD   = 6'd28;
  localparam logic [INST_OP_WIDTH-1:0] OP_SUB   = 6'd29;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLL   = 6'd30;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLT   = 6'd31;
  localparam logic [INST_OP_WIDTH-1:0] OP_SLTU  = 6'd32;
  localparam logic [INST_OP_WIDTH-1:0] OP_XOR   = 6'd33;
  localparam logic [INST_OP_WIDTH-1:0] OP_SRL   = 6'd34;
  localparam logic [INST_OP_WIDTH-1:0] OP_SRA   = 6'd35;
  localparam logic [INST_OP_WIDTH-1:0] OP_OR    = 6'd36;
  localparam logic [INST_OP_WIDTH-1:0] OP_AND   = 6'd37;

  // What a committing entry does: register write, nothing (branch), or store release.
  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2
  } rob_kind_e;

  // Commit control: normal run, one cycle to expose the mispredicted commit,
  // one cycle of flush pulse.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FLUSH = 2'd2
  } rob_state_e;

  // Classify a decoded opcode into its commit behaviour.
  function automatic rob_kind_e op_kind(input logic [INST_OP_WIDTH-1:0] op);
    rob_kind_e kind;
    if ((op >= OP_BEQ) && (op <= OP_BGEU)) begin
      kind = KIND_BRANCH;
    end else if ((op >= OP_SB) && (op <= OP_SW)) begin
      kind = KIND_STORE;
    end else begin
      kind = KIND_REG;
    end
    return kind;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Reorder buffer: circular in-order commit queue. Allocates at tail,
// collects ALU/LSB writebacks, retires one entry per cycle at head and
// drives register-file commit writes, store-commit pulses and the
// mispredict flush.
// Optional feature macro: ROB_WB_BYPASS_EN (forward same-cycle writebacks
// onto the operand query outputs).
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rdy,
  input  logic                          stall,
  input  logic                          dec_ready,
  input  logic [INST_OP_WIDTH-1:0]      dec_op,
  input  logic [REG_CNT_WIDTH-1:0]      dec_rd,
  input  logic [2*ROB_SIZE_WIDTH-1:0]   dec_query_ids,
  input  logic                          alu_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]     alu_rob_id,
  input  logic [XLEN-1:0]               alu_val,
  input  logic                          alu_mispredict,
  input  logic [XLEN-1:0]               alu_target,
  input  logic                          lsb_ready,
  input  logic [ROB_SIZE_WIDTH-1:0]     lsb_rob_id,
  input  logic [XLEN-1:0]               lsb_val,
  output logic                          rob_full,
  output logic [ROB_SIZE_WIDTH-1:0]     rob_head_id,
  output logic [ROB_SIZE_WIDTH-1:0]     rob_tail_id,
  output logic                          rob_rf_enable,
  output logic [REG_CNT_WIDTH-1:0]      rob_rf_rd,
  output logic [XLEN-1:0]               rob_rf_val,
  output logic                          rob_store_commit,
  output logic                          rob_flush,
  output logic [XLEN-1:0]               rob_flush_pc,
  output logic [1:0]                    rob_query_ready,
  output logic [2*XLEN-1:0]             rob_query_val
);

  localparam logic [ROB_SIZE_WIDTH:0]   CNT_FULL = (ROB_SIZE_WIDTH+1)'(ROB_ENTRIES);
  localparam logic [ROB_SIZE_WIDTH:0]   CNT_ONE  = (ROB_SIZE_WIDTH+1)'(1);
  localparam logic [ROB_SIZE_WIDTH-1:0] ID_ONE   = ROB_SIZE_WIDTH'(1);

  // Entry storage
  logic [ROB_ENTRIES-1:0]     r_valid;
  logic [ROB_ENTRIES-1:0]     r_ready;
  logic [ROB_ENTRIES-1:0]     r_mispred;
  rob_kind_e                  r_kind   [ROB_ENTRIES];
  logic [REG_CNT_WIDTH-1:0]   r_rd     [ROB_ENTRIES];
  logic [XLEN-1:0]            r_val    [ROB_ENTRIES];
  logic [XLEN-1:0]            r_target [ROB_ENTRIES];

  // Queue pointers and control
  logic [ROB_SIZE_WIDTH-1:0]  r_head;
  logic [ROB_SIZE_WIDTH-1:0]  r_tail;
  logic [ROB_SIZE_WIDTH:0]    r_count;
  rob_state_e                 r_state;
  logic [XLEN-1:0]            r_redirect_pc;

  logic                       w_alloc;
  logic                       w_commit;
  logic [ROB_SIZE_WIDTH-1:0]  w_qid [2];

  // Full is derived from registered occupancy only, so an allocation can
  // never use the slot being freed by a commit in the same cycle.
  assign rob_full    = (r_count == CNT_FULL) || (r_state != ST_RUN);
  assign rob_head_id = r_head;
  assign rob_tail_id = r_tail;

  assign w_alloc  = rdy && dec_ready && !stall && !rob_full;
  assign w_commit = rdy && (r_state == ST_RUN) && r_valid[r_head] && r_ready[r_head];

  assign w_qid[0] = dec_query_ids[ROB_SIZE_WIDTH-1:0];
  assign w_qid[1] = dec_query_ids[2*ROB_SIZE_WIDTH-1:ROB_SIZE_WIDTH];

  // Allocation, writeback, commit and flush sequencing; everything freezes while rdy is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid          <= '0;
      r_ready          <= '0;
      r_mispred        <= '0;
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        r_kind[i]   <= KIND_REG;
        r_rd[i]     <= '0;
        r_val[i]    <= '0;
        r_target[i] <= '0;
      end
      r_head           <= '0;
      r_tail           <= '0;
      r_count          <= '0;
      r_state          <= ST_RUN;
      r_redirect_pc    <= '0;
      rob_rf_enable    <= 1'b0;
      rob_rf_rd        <= '0;
      rob_rf_val       <= '0;
      rob_store_commit <= 1'b0;
      rob_flush        <= 1'b0;
      rob_flush_pc     <= '0;
    end else if (rdy) begin
      rob_rf_enable    <= 1'b0;
      rob_store_commit <= 1'b0;
      rob_flush        <= 1'b0;

      if (alu_ready) begin
        r_val[alu_rob_id]     <= alu_val;
        r_ready[alu_rob_id]   <= 1'b1;
        r_mispred[alu_rob_id] <= alu_mispredict;
        r_target[alu_rob_id]  <= alu_target;
      end
      if (lsb_ready) begin
        r_val[lsb_rob_id]   <= lsb_val;
        r_ready[lsb_rob_id] <= 1'b1;
      end

      if (w_alloc) begin
        r_valid[r_tail]   <= 1'b1;
        r_ready[r_tail]   <= 1'b0;
        r_mispred[r_tail] <= 1'b0;
        r_kind[r_tail]    <= op_kind(dec_op);
        r_rd[r_tail]      <= dec_rd;
        r_tail            <= r_tail + ID_ONE;
      end

      if (w_commit) begin
        r_valid[r_head]  <= 1'b0;
        r_ready[r_head]  <= 1'b0;
        r_head           <= r_head + ID_ONE;
        rob_rf_enable    <= (r_kind[r_head] == KIND_REG) && (r_rd[r_head] != '0);
        rob_rf_rd        <= r_rd[r_head];
        rob_rf_val       <= r_val[r_head];
        rob_store_commit <= (r_kind[r_head] == KIND_STORE);
      end

      case ({w_alloc, w_commit})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase

      case (r_state)
        ST_RUN: begin
          if (w_commit && r_mispred[r_head]) begin
            r_redirect_pc <= r_target[r_head];
            r_state       <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          rob_flush    <= 1'b1;
          rob_flush_pc <= r_redirect_pc;
          r_state      <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Squash everything younger than the mispredicted instruction.
          r_valid   <= '0;
          r_ready   <= '0;
          r_mispred <= '0;
          r_head    <= '0;
          r_tail    <= '0;
          r_count   <= '0;
          r_state   <= ST_RUN;
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Operand queries for the two source tags of the instruction being decoded.
  always_comb begin
    rob_query_ready = '0;
    rob_query_val   = '0;
    for (int q = 0; q < 2; q++) begin
      rob_query_ready[q]             = r_valid[w_qid[q]] && r_ready[w_qid[q]];
      rob_query_val[q*XLEN +: XLEN]  = r_val[w_qid[q]];
`ifdef ROB_WB_BYPASS_EN
      if (alu_ready && (alu_rob_id == w_qid[q])) begin
        rob_query_ready[q]            = 1'b1;
        rob_query_val[q*XLEN +: XLEN] = alu_val;
      end else if (lsb_ready && (lsb_rob_id == w_qid[q])) begin
        rob_query_ready[q]            = 1'b1;
        rob_query_val[q*XLEN +: XLEN] = lsb_val;
      end else begin
        rob_query_ready[q]            = rob_query_ready[q];
      end
`endif
    end
  end

endmodule

// File: doc/reorder_buffer.md
Name:
reorder_buffer

Overview:
Circular in-order commit buffer between decoder/issue and the register_file; allocates entries at tail_id, collects ALU/LSB writebacks, retires at head, drives rob_rf_* commit writes, store-commit pulses and mispredict flush.

Parameters:
ROB_SIZE_WIDTH, 3, log2 entry count (8 entries); dependency tag width is ROB_SIZE_WIDTH+1, MSB=1 means no dependency
XLEN, 32, data width
REG_CNT_WIDTH, 5, architectural register index width

Ports:
clk  in  1  clock
rst  in  1  reset
rdy  in  1  global enable; low freezes all state
stall  in  1  issue stall from RS/LSB; blocks allocation
dec_ready  in  1  decoded instruction valid
dec_op  in  INST_OP_WIDTH  opcode (shared package encoding)
dec_rd  in  REG_CNT_WIDTH  destination register
dec_query_ids  in  2*ROB_SIZE_WIDTH  {rs2 tag, rs1 tag} from rf_dep low bits
alu_ready  in  1  ALU writeback valid
alu_rob_id  in  ROB_SIZE_WIDTH  ALU writeback entry
alu_val  in  XLEN  ALU result
alu_mispredict  in  1  branch/JALR resolved against prediction
alu_target  in  XLEN  correct next PC
lsb_ready  in  1  LSB writeback valid (load data or store address done)
lsb_rob_id  in  ROB_SIZE_WIDTH  LSB writeback entry
lsb_val  in  XLEN  load result (ignored for stores)
rob_full  out  1  occupancy == 2^ROB_SIZE_WIDTH or not in RUN
rob_head_id  out  ROB_SIZE_WIDTH  oldest uncommitted entry
rob_tail_id  out  ROB_SIZE_WIDTH  entry the next allocation receives
rob_rf_enable  out  1  registered commit write
rob_rf_rd  out  REG_CNT_WIDTH  commit destination
rob_rf_val  out  XLEN  commit value
rob_store_commit  out  1  one-cycle pulse: oldest store may write memory
rob_flush  out  1  one-cycle global flush
rob_flush_pc  out  XLEN  redirect PC, valid with rob_flush
rob_query_ready  out  2  {rs2,rs1} entry has result
rob_query_val  out  2*XLEN  {rs2,rs1} entry result

Behaviour:
- Reset (rst synchronous, active-high; clk): head=tail=0, count=0, all entries invalid, state RUN; every output 0 except rob_full=0.
- Allocate when rdy && dec_ready && !stall && !rob_full: entry[tail] <= {valid, ready=0, kind, rd}; tail+1 mod 2^W. Kind: BEQ..BGEU -> BRANCH (no rd write); SB/SH/SW -> STORE (no rd write); else REG. rd=0 never written to RF.
- Writeback: alu_ready sets entry val/ready/mispredict/target; lsb_ready sets val/ready. Both same cycle on different ids both apply; same id is an upstream error.
- Commit (RUN, entry[head] valid && ready): at that edge head+1, count-1, entry cleared; registered outputs: rob_rf_enable=(REG/BRANCH-with-rd && rd!=0), rd, val; rob_store_commit=1 for STORE. Hence rob_head_id already equals committed id+1 whenever rob_rf_enable=1 (register_file relies on this). One commit per cycle max.
- Same-cycle allocate+commit: count unchanged; full uses registered count (no same-cycle credit).
- Mispredict: committing entry with mispredict -> state DRAIN (its rf write visible this cycle, rob_full=1, no commit/alloc) -> FLUSH (rob_flush=1, rob_flush_pc=target) -> at that edge head=tail=count=0, all entries invalid, -> RUN.
- Queries combinational: ready=entry valid&&ready, val=entry val.
- rdy low: no state change; pulses hold value.

Optional Feature:
ROB_WB_BYPASS_EN: defined -> query outputs also forward same-cycle alu/lsb writeback matching the id (ALU priority); undefined -> registered entry contents only (one-cycle later visibility).

Decomposition:
Shared package: ROB_SIZE_WIDTH, DEPENDENCY_WIDTH, opcode defines, entry-kind constants, state encodings. No sub-module; single module with entry arrays.

Test Plan:
- Reset, alloc ADD rd=5, ALU writeback val=0x1234 -> next-cycle rob_rf_enable=1, rd=5, val=0x1234, rob_head_id=1.
- Fill 8 entries no writeback -> rob_full=1, 9th dec_ready ignored, tail stays 0; commit one -> rob_full=0.
- Tail wrap: 20 alloc/commit pairs -> ids wrap 7->0, in-order commits, count never exceeds 8.
- JALR rd=1 mispredict target=0x100 -> rf write rd=1 cycle N, rob_flush=1 pc=0x100 cycle N+1, head=tail=0 after.
- SW allocated, lsb_ready -> rob_store_commit pulses exactly once, rob_rf_enable=0.
- Bypass: query id=3 with alu_ready id=3 same cycle -> ready=1 when ROB_WB_BYPASS_EN defined, 0 when not.
